// File: rtl/cw_arbiter.sv
// Two-master round-robin arbiter in front of the compressed-bus decompressor.
// A grant owns the bus for two header words plus a 1, 4 or 8 word data burst.
`timescale 1ns/1ps

module cw_arbiter #(
    parameter int unsigned RW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,

    input  logic [RW-1:0] m0_cw_io_i,
    input  logic          m0_cw_req,
    input  logic          m0_cw_dir,
    output logic [RW-1:0] m0_cw_io_o,
    output logic          m0_cw_ack,
    output logic          m0_cw_err,

    input  logic [RW-1:0] m1_cw_io_i,
    input  logic          m1_cw_req,
    input  logic          m1_cw_dir,
    output logic [RW-1:0] m1_cw_io_o,
    output logic          m1_cw_ack,
    output logic          m1_cw_err,

    output logic [RW-1:0] s_cw_io_o,
    output logic          s_cw_req,
    output logic          s_cw_dir,
    input  logic [RW-1:0] s_cw_io_i,
    input  logic          s_cw_ack,
    input  logic          s_cw_err,

    output logic          o_busy,
    output logic          o_owner
);

    typedef enum logic [1:0] {StIdle, StHdr0, StHdr1, StData} state_e;

    state_e      state_q;
    logic        owner_q;
    logic        rr_q;
    logic        busy_q;
    logic [2:0]  last_q;
    logic [2:0]  cnt_q;

    logic        m0_rq;
    logic        m1_rq;
    logic        grant_any;
    logic        grant_idx;
    logic [3:0]  hdr_len;
    logic [2:0]  len_last;
    logic        beat;

    // A request needs both req and the start bit of the header word.
    assign m0_rq     = m0_cw_req & m0_cw_io_i[0];
    assign m1_rq     = m1_cw_req & m1_cw_io_i[0];
    assign grant_any = m0_rq | m1_rq;
    assign grant_idx = (m0_rq & m1_rq) ? ~rr_q : m1_rq;
    assign hdr_len   = grant_idx ? m1_cw_io_i[7:4] : m0_cw_io_i[7:4];
    assign beat      = s_cw_ack | s_cw_err;

    // Stored as the index of the final beat so completion is a direct compare.
    always_comb begin
        if (hdr_len == 4'd0) begin
            len_last = 3'd0;
        end else if (hdr_len[0]) begin
            len_last = 3'd7;
        end else begin
            len_last = 3'd3;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            rr_q    <= 1'b1;
            busy_q  <= 1'b0;
            last_q  <= 3'd0;
            cnt_q   <= 3'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_any) begin
                        owner_q <= grant_idx;
                        last_q  <= len_last;
                        cnt_q   <= 3'd0;
                        busy_q  <= 1'b1;
                        state_q <= StHdr0;
                    end
                end
                StHdr0: begin
                    if (s_cw_ack) begin
                        state_q <= StHdr1;
                    end
                end
                StHdr1: begin
                    state_q <= StData;
                end
                StData: begin
                    // An error beat completes the word just like an ack; no early abort.
                    if (beat) begin
                        if (cnt_q == last_q) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            rr_q    <= owner_q;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        s_cw_io_o  = '0;
        s_cw_req   = 1'b0;
        s_cw_dir   = 1'b0;
        m0_cw_io_o = '0;
        m0_cw_ack  = 1'b0;
        m0_cw_err  = 1'b0;
        m1_cw_io_o = '0;
        m1_cw_ack  = 1'b0;
        m1_cw_err  = 1'b0;
        if (state_q != StIdle) begin
            if (owner_q) begin
                s_cw_io_o  = m1_cw_io_i;
                s_cw_req   = m1_cw_req;
                s_cw_dir   = m1_cw_dir;
                m1_cw_io_o = s_cw_io_i;
                m1_cw_ack  = s_cw_ack;
                m1_cw_err  = s_cw_err;
            end else begin
                s_cw_io_o  = m0_cw_io_i;
                s_cw_req   = m0_cw_req;
                s_cw_dir   = m0_cw_dir;
                m0_cw_io_o = s_cw_io_i;
                m0_cw_ack  = s_cw_ack;
                m0_cw_err  = s_cw_err;
            end
        end
    end

    assign o_busy  = busy_q;
    assign o_owner = owner_q;

endmodule
